// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: four-requester round-robin arbiter feeding one 8N1 UART
// transmitter. Build with UART_TX_PARITY_EN defined to add an even-parity bit
// (8E1, 11-bit frame); the default build sends a 10-bit frame.
//
// Ports
//   clk      rising-edge clock
//   rst      asynchronous active-low reset
//   req      per-requester transmit request, bit i = requester i
//   data     requester i's byte on data[8i+7:8i]
//   ack      one-hot, one-cycle acceptance pulse for the granted requester
//   grant_id index of the requester whose byte is on the line
//   busy     high whenever the transmitter is not idle
//   tx       serial line, idle high
module uart_tx_arbiter #(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] data,
  output logic [3:0]  ack,
  output logic [1:0]  grant_id,
  output logic        busy,
  output logic        tx
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD;
  localparam int unsigned DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
    ,S_PARITY = 3'd4
`endif
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       tx_byte;
  logic [1:0]       last_grant;
  logic             bit_end_c;
  logic             found_c;
  logic [1:0]       winner_c;

  assign bit_end_c = (div_cnt == DIV_LAST);

  // Round-robin pick: first asserted request after last_grant, ascending with wrap.
  always_comb begin
    logic [1:0] cand;
    found_c  = 1'b0;
    winner_c = '0;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!found_c && req[cand]) begin
        found_c  = 1'b1;
        winner_c = cand;
      end
    end
  end

  // Baud divider: held at zero while idle so every frame starts on a fresh count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt <= '0;
    end else if (state == S_IDLE || bit_end_c) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // Arbitration and frame sequencing; tx is updated on the edge entering each bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      ack        <= '0;
      grant_id   <= '0;
      busy       <= 1'b0;
      tx         <= 1'b1;
      bit_cnt    <= '0;
      tx_byte    <= '0;
      last_grant <= 2'd3;
    end else begin
      ack <= '0;
      case (state)
        S_IDLE: begin
          if (found_c) begin
            ack        <= 4'b0001 << winner_c;
            tx_byte    <= data[{winner_c, 3'b000} +: 8];
            grant_id   <= winner_c;
            last_grant <= winner_c;
            busy       <= 1'b1;
            tx         <= 1'b0;
            bit_cnt    <= '0;
            state      <= S_START;
          end
        end
        S_START: begin
          if (bit_end_c) begin
            tx      <= tx_byte[0];
            bit_cnt <= '0;
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end_c) begin
            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              tx    <= ^tx_byte;
              state <= S_PARITY;
`else
              tx    <= 1'b1;
              state <= S_STOP;
`endif
            end else begin
              tx      <= tx_byte[bit_cnt + 3'd1];
              bit_cnt <= bit_cnt + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end_c) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (bit_end_c) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          tx    <= 1'b1;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a cycle-level reference model predicts
// each grant (winner, byte, grant cycle); a monitor pops on every ack and
// checks the whole serial frame bit-by-bit.
module tb_uart_tx_arbiter;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 100_000;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic        clk  = 1'b0;
  logic        rst  = 1'b1;
  logic [3:0]  req  = '0;
  logic [31:0] data = '0;
  logic [3:0]  ack;
  logic [1:0]  grant_id;
  logic        busy;
  logic        tx;

  uart_tx_arbiter #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .rst(rst), .req(req), .data(data),
    .ack(ack), .grant_id(grant_id), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] b;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int free_at = 0;
  int m_last  = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Frame as a bit vector: index 0 start, 1..8 data LSB first, then parity/stop.
  function automatic logic exp_bit(input logic [7:0] b, input int idx);
    logic [10:0] f;
`ifdef UART_TX_PARITY_EN
    f = {1'b1, ^b, b, 1'b0};
`else
    f = {1'b0, 1'b1, b, 1'b0};
`endif
    return f[idx];
  endfunction

  // Reference model: the line is free NB*DIV+1 edges after a grant.
  always @(posedge clk) begin
    int   w;
    logic found;
    cyc++;
    if (!rst) begin
      m_last  = 3;
      free_at = 0;
    end else if (cyc >= free_at && req != 4'd0) begin
      found = 1'b0;
      w     = 0;
      for (int k = 1; k <= 4; k++) begin
        if (!found && req[(m_last + k) % 4]) begin
          found = 1'b1;
          w     = (m_last + k) % 4;
        end
      end
      sb.push_back('{id: w, b: data[8*w +: 8], cyc: cyc});
      m_last  = w;
      free_at = cyc + NB * DIV + 1;
    end
  end

  // Monitor: every ack starts a frame that is checked cycle by cycle.
  initial begin : mon
    exp_t e;
    logic aborted;
    forever begin
      @(negedge clk);
      if (rst && ack != 4'd0) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", 32'(ack), 32'd0);
        end else begin
          e = sb.pop_front();
          chk("grant_cycle", 32'(cyc), 32'(e.cyc));
          chk("ack_onehot", 32'(ack), 32'(1) << e.id);
          chk("grant_id", 32'(grant_id), 32'(e.id));
          chk("busy_start", 32'(busy), 32'd1);
          chk("tx_start", 32'(tx), 32'd0);
          aborted = 1'b0;
          for (int j = 1; j < NB * DIV; j++) begin
            @(negedge clk);
            if (!rst) begin
              aborted = 1'b1;
              break;
            end
            chk("tx_bit", 32'(tx), 32'(exp_bit(e.b, j / DIV)));
            chk("ack_quiet", 32'(ack), 32'd0);
            chk("grant_id_hold", 32'(grant_id), 32'(e.id));
            chk("busy_frame", 32'(busy), 32'd1);
          end
          if (!aborted) begin
            @(negedge clk);
            if (rst) begin
              chk("busy_idle", 32'(busy), 32'd0);
              chk("tx_idle", 32'(tx), 32'd1);
              chk("ack_idle", 32'(ack), 32'd0);
            end
          end
        end
      end
    end
  end

  task automatic wait_ack();
    logic got;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (ack != 4'd0) begin
        got = 1'b1;
        break;
      end
    end
    chk("ack_wait", 32'(got), 32'd1);
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cyc >= free_at) begin
        done = 1'b1;
        break;
      end
    end
    chk("idle_wait", 32'(done), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ack", 32'(ack), 32'd0);
    chk("rst_grant_id", 32'(grant_id), 32'd0);

    // Single request, byte 0x55, granted on the first edge after release.
    req  = 4'b0001;
    data = 32'h0000_0055;
    rst  = 1'b1;
    wait_ack();
    req = 4'b0000;
    wait_idle();

    // All four held: order 0,1,2,3,0 with one idle cycle between frames.
    req  = 4'b1111;
    data = 32'hA3A2_A1A0;
    repeat (5) wait_ack();
    req = 4'b0000;
    wait_idle();

    // Grant to 1, then 1010 gives 3 then 1.
    req = 4'b0010;
    wait_ack();
    req = 4'b1010;
    repeat (2) wait_ack();
    req = 4'b0000;
    wait_idle();

    // Data changed mid-frame must not reach the line.
    req  = 4'b0001;
    data = 32'h0000_000F;
    wait_ack();
    req = 4'b0000;
    repeat (25) @(negedge clk);
    data = 32'h0000_00F0;
    wait_idle();

    // Byte 0x07 (odd weight: parity bit 1 when enabled).
    req  = 4'b0001;
    data = 32'h0000_0007;
    wait_ack();
    req = 4'b0000;
    wait_idle();

    // Randomised traffic: data churns every cycle, req changes occasionally.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      data = $urandom;
      if ($urandom_range(0, 29) == 0) req = 4'($urandom_range(0, 15));
    end
    req = 4'b0000;
    wait_idle();

    // Asynchronous reset during DATA bit 3 (a zero bit of 0xA5).
    req  = 4'b0001;
    data = 32'h0000_00A5;
    wait_ack();
    req = 4'b0000;
    repeat (44) @(negedge clk);
    #3 rst = 1'b0;
    #1;
    chk("abort_tx", 32'(tx), 32'd1);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_grant_id", 32'(grant_id), 32'd0);
    @(negedge clk);
    req  = 4'b0100;
    data = 32'h005A_0000;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    wait_ack();
    chk("post_rst_grant_id", 32'(grant_id), 32'd2);
    req = 4'b0000;
    wait_idle();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLK_FREQ, default 100_000_000, SHALL set the clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, SHALL set the line bit rate; DIV = CLK_FREQ/BAUD (integer division), with DIV >= 2 required.
REQ-003 Port clk, input, 1, SHALL be the single rising-edge clock.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-low reset (0 = reset).
REQ-005 Port req, input, 4, SHALL carry one transmit-request bit per requester, bit i belonging to requester i.
REQ-006 Port data, input, 32, SHALL carry requester i's byte on bits [8i+7:8i].
REQ-007 Port ack, output, 4, SHALL be the one-hot, one-cycle acceptance pulse for the granted requester.
REQ-008 Port grant_id, output, 2, SHALL hold the index of the requester whose byte is on the line.
REQ-009 Port busy, output, 1, SHALL be high whenever the FSM is not IDLE.
REQ-010 Port tx, output, 1, SHALL be the serial line, idle high.

Function
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, plus PARITY when UART_TX_PARITY_EN is defined.
REQ-012 In IDLE with req != 0, the arbiter SHALL choose the winner round-robin: search starts at (last_grant+1) mod 4, ascending with wrap.
REQ-013 On the grant cycle, the arbiter SHALL pulse ack[winner] high for exactly one cycle, latch the winner's byte and index, and enter START next cycle.
REQ-014 ack SHALL be zero in all non-grant cycles, and at most one ack bit SHALL ever be high.
REQ-015 A req bit that drops before its ack SHALL receive no grant; req held after ack SHALL be treated as a new request at the next IDLE.
REQ-016 The internal baud divider SHALL clear on entry to START and produce a bit_end tick when its count equals DIV-1, then wrap to 0.
REQ-017 Each line bit SHALL last exactly DIV clocks.
REQ-018 Frame order SHALL be: START (tx=0); DATA with 8 bits LSB first; optional PARITY; STOP (tx=1).
REQ-019 tx SHALL be registered, changing on the clock edge that enters each bit.
REQ-020 After STOP's bit_end the FSM SHALL return to IDLE, giving a minimum of one IDLE cycle between back-to-back frames.
REQ-021 The latched byte and grant_id SHALL remain stable for the whole frame; changes on data or req mid-frame SHALL have no effect.
REQ-022 last_grant SHALL update only on a grant cycle.

Reset
REQ-023 While rst=0, outputs SHALL be: tx=1, busy=0, ack=0, grant_id=0; internally state=IDLE, divider=0, bit counter=0, last_grant=3 so that requester 0 has first priority.
REQ-024 Reset asserted mid-frame SHALL abort the frame immediately, without waiting for a clock edge, driving tx high.
REQ-025 The first grant SHALL be possible on the first rising edge after rst deasserts.

Configuration
REQ-026 With macro UART_TX_PARITY_EN defined, an even-parity bit (XOR of the 8 data bits) SHALL be sent for DIV clocks between DATA and STOP, giving an 11-bit frame.
REQ-027 Without UART_TX_PARITY_EN, the PARITY state and its logic SHALL be absent, giving a 10-bit frame: DATA goes directly to STOP.

Verification (CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10)
REQ-028 Single request, req=4'b0001 with byte 0x55 -> ack=0001 for 1 cycle; tx sequence 0,1,0,1,0,1,0,1,0,1, each bit 10 clocks; busy high for 100 clocks (110 with parity, parity bit 0).
REQ-029 All four requesters held continuously, bytes 0xA0..0xA3 -> grant order 0,1,2,3,0; frames separated by exactly 1 idle cycle.
REQ-030 req=4'b1010 after a grant to 1 -> next grant 3, then 1.
REQ-031 data[7:0] changed from 0x0F to 0xF0 during DATA of a frame carrying 0x0F -> line still shows 0x0F.
REQ-032 rst pulled low during bit 3 of DATA -> tx=1 and busy=0 asynchronously; after release with req=4'b0100, a clean frame is sent with grant_id=2.
REQ-033 Byte 0x07 with UART_TX_PARITY_EN defined -> parity bit 1; frame length 110 clocks.
